// File: rtl/half_adder.sv
// Registered bit-parallel half adder: per-lane sum = a ^ b, carry = a & b, with no
// inter-lane carry. One-cycle latency, one result per cycle, no backpressure.
module half_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;

  // Results hold across idle cycles; operands are only looked at when in_valid is set,
  // so X on a/b during idle cycles never reaches the registers.
  always_comb begin
    valid_d = in_valid;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (in_valid) begin
      sum_d   = a ^ b;
      carry_d = a & b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: expected sum/carry pushed to a scoreboard queue
// when operands are driven, popped and compared after the capturing clock edge.
module tb_half_adder;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] sum;
  logic [W-1:0] carry;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   hold_sum;
  logic [W-1:0]   hold_carry;

  half_adder #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .sum      (sum),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, wait for the capturing edge, then check the outputs.
  task automatic step(input logic r, input logic v, input logic [W-1:0] av,
                      input logic [W-1:0] bv);
    logic [2*W-1:0] exp;
    logic [W:0]     lhs;
    logic [W:0]     rhs;
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    if (!r && v) sb_q.push_back({av ^ bv, av & bv});
    @(posedge clk);
    #1;
    if (r) begin
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_sum", 64'(sum), 64'(0));
      check("rst_carry", 64'(carry), 64'(0));
      hold_sum   = '0;
      hold_carry = '0;
    end else if (v) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 64'(1), 64'(0));
      end else begin
        exp = sb_q.pop_front();
        check("out_valid", 64'(out_valid), 64'(1));
        check("sum", 64'(sum), 64'(exp[2*W-1:W]));
        check("carry", 64'(carry), 64'(exp[W-1:0]));
        lhs = {1'b0, sum} + {carry, 1'b0};
        rhs = {1'b0, av} + {1'b0, bv};
        check("invariant", 64'(lhs), 64'(rhs));
        hold_sum   = exp[2*W-1:W];
        hold_carry = exp[W-1:0];
      end
    end else begin
      check("idle_valid", 64'(out_valid), 64'(0));
      check("hold_sum", 64'(sum), 64'(hold_sum));
      check("hold_carry", 64'(carry), 64'(hold_carry));
    end
  endtask

  initial begin
    logic [W-1:0] xv;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    hold_sum   = '0;
    hold_carry = '0;
    xv         = 'x;

    // Reset held for two cycles with a valid operand pair presented.
    step(1'b1, 1'b1, 32'd5, 32'd3);
    step(1'b1, 1'b1, 32'd5, 32'd3);

    // Basic and boundary operand patterns.
    step(1'b0, 1'b1, 32'd5, 32'd3);
    check("basic_sum_lit", 64'(sum), 64'd6);
    check("basic_carry_lit", 64'(carry), 64'd1);
    step(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("ones_sum_lit", 64'(sum), 64'h0);
    check("ones_carry_lit", 64'(carry), 64'hFFFF_FFFF);
    step(1'b0, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
    check("alt_sum_lit", 64'(sum), 64'hFFFF_FFFF);
    check("alt_carry_lit", 64'(carry), 64'h0);
    step(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);

    // Hold: results persist across idle cycles, including X operands.
    step(1'b0, 1'b1, 32'd12, 32'd10);
    step(1'b0, 1'b0, 32'd1, 32'd1);
    check("hold_sum_lit", 64'(sum), 64'd6);
    check("hold_carry_lit", 64'(carry), 64'd8);
    step(1'b0, 1'b0, xv, xv);

    // Back-to-back random stream.
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, W'($urandom()), W'($urandom()));
    end

    // Reset in the middle of a valid stream drops that operand pair.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'($urandom()), W'($urandom()));
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
    step(1'b0, 1'b0, 32'd7, 32'd7);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'($urandom()), W'($urandom()));

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
